// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory read channel plus the decode-side
// handshake (stall/redirect in, inst/inst_pc/inst_valid out).
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;

   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid,
      input  imem_ready, imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid,
      output imem_ready, imem_rdata, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding-request instruction fetch unit: issues one word read,
// holds the result for decode, and discards responses made stale by a redirect.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst_n,
   inst_fetch_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DELIVER, FLUSH} fetchState_e;

   fetchState_e state, nextState;
   logic [31:0] pc, pcNext;
   logic [31:0] reqAddr, reqAddrNext;
   logic [31:0] instReg, instNext;
   logic [31:0] instPcReg, instPcNext;
   logic        instValidReg, instValidNext;
   logic [31:0] redirectTarget;

   assign redirectTarget = {bus.redirect_pc[31:2], 2'b00};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         reqAddr      <= RESET_PC;
         instReg      <= 32'h0;
         instPcReg    <= 32'h0;
         instValidReg <= 1'b0;
      end else begin
         pc           <= pcNext;
         reqAddr      <= reqAddrNext;
         instReg      <= instNext;
         instPcReg    <= instPcNext;
         instValidReg <= instValidNext;
      end
   end

   // A redirect always retargets pc; what happens to the in-flight request
   // depends on whether memory has already answered it.
   always_comb begin
      nextState     = state;
      pcNext        = pc;
      reqAddrNext   = reqAddr;
      instNext      = instReg;
      instPcNext    = instPcReg;
      instValidNext = instValidReg;
      if (bus.redirect) pcNext = redirectTarget;
      case (state)
         IDLE: begin
            nextState     = FETCH;
            instValidNext = 1'b0;
            reqAddrNext   = bus.redirect ? redirectTarget : pc;
         end
         FETCH: begin
            if (bus.redirect) begin
               if (bus.imem_ready) reqAddrNext = redirectTarget;
               else                nextState   = FLUSH;
            end else if (bus.imem_ready) begin
               instNext      = bus.imem_rdata;
               instPcNext    = reqAddr;
               instValidNext = 1'b1;
               pcNext        = pc + 32'd4;
               nextState     = DELIVER;
            end
         end
         DELIVER: begin
            if (bus.redirect) begin
               instValidNext = 1'b0;
               reqAddrNext   = redirectTarget;
               nextState     = FETCH;
            end else if (!bus.stall) begin
               instValidNext = 1'b0;
               reqAddrNext   = pc;
               nextState     = FETCH;
            end
         end
         FLUSH: begin
            // The stale response is dropped; restart from the newest pc.
            if (bus.imem_ready) begin
               reqAddrNext = pcNext;
               nextState   = FETCH;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign bus.imem_req   = (state == FETCH) || (state == FLUSH);
   assign bus.imem_addr  = reqAddr;
   assign bus.inst       = instReg;
   assign bus.inst_pc    = instPcReg;
   assign bus.inst_valid = instValidReg;

endmodule
